// File: rtl/reset_sequencer.sv
// Power-on / relock reset sequencer: waits for a stable PLL lock, releases peripheral reset,
// then releases CPU reset after a fixed delay; lock loss or a debounced button press restarts it.
module reset_sequencer #(
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int CPU_DELAY_CYCLES   = 64,
   parameter int DEBOUNCE_CYCLES    = 65536
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       button_rst,
   output logic       periph_rst,
   output logic       cpu_rst,
   output logic       seq_done,
   output logic [7:0] relock_count
);

   localparam int CNT_MAX = (LOCK_STABLE_CYCLES > CPU_DELAY_CYCLES) ? LOCK_STABLE_CYCLES
                                                                    : CPU_DELAY_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CPU_LAST  = CNT_W'(CPU_DELAY_CYCLES - 1);
   localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK  = 2'd0,
      LOCK_WAIT  = 2'd1,
      PERIPH_RUN = 2'd2,
      RUN        = 2'd3
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_next;
   logic [7:0]         relock_next;
   logic               abort;

   logic               locked_m;
   logic               locked_s;
   logic               button_m;
   logic               button_s;
   logic [DEB_W-1:0]   deb_cnt;
   logic               btn_deb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         locked_m <= 1'b0;
         locked_s <= 1'b0;
         button_m <= 1'b0;
         button_s <= 1'b0;
      end else begin
         locked_m <= pll_locked;
         locked_s <= locked_m;
         button_m <= button_rst;
         button_s <= button_m;
      end
   end

   // Any low sample drops the debounced press and restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_cnt <= '0;
         btn_deb <= 1'b0;
      end else if (!button_s) begin
         deb_cnt <= '0;
         btn_deb <= 1'b0;
      end else if (deb_cnt == DEB_LAST) begin
         btn_deb <= 1'b1;
      end else begin
         deb_cnt <= deb_cnt + 1'b1;
      end
   end

   assign abort = !locked_s || btn_deb;

   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      relock_next = relock_count;
      case (state)
         WAIT_LOCK: begin
            if (locked_s && !btn_deb) begin
               state_next = LOCK_WAIT;
               cnt_next   = '0;
            end
         end
         LOCK_WAIT: begin
            if (abort) begin
               state_next = WAIT_LOCK;
               cnt_next   = '0;
            end else if (cnt == LOCK_LAST) begin
               state_next = PERIPH_RUN;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         PERIPH_RUN: begin
            if (abort) begin
               state_next = WAIT_LOCK;
               cnt_next   = '0;
            end else if (cnt == CPU_LAST) begin
               state_next = RUN;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         RUN: begin
            if (abort) begin
               state_next = WAIT_LOCK;
               cnt_next   = '0;
               // Only lock loss counts; a button-only exit leaves the counter alone.
               if (!locked_s && relock_count != 8'hFF)
                  relock_next = relock_count + 8'd1;
            end
         end
         default: begin
            state_next = WAIT_LOCK;
            cnt_next   = '0;
         end
      endcase
   end

   // Outputs decode the next state so they switch on the same edge as the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= WAIT_LOCK;
         cnt          <= '0;
         relock_count <= 8'd0;
         periph_rst   <= 1'b1;
         cpu_rst      <= 1'b1;
         seq_done     <= 1'b0;
      end else begin
         state        <= state_next;
         cnt          <= cnt_next;
         relock_count <= relock_next;
         periph_rst   <= !(state_next == PERIPH_RUN || state_next == RUN);
         cpu_rst      <= (state_next != RUN);
         seq_done     <= (state_next == RUN);
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with LOCK=16, CPU=8, DEBOUNCE=4; edges counted from the
// first edge that samples a changed input.
module tb_reset_sequencer;

   logic       clk;
   logic       rst_n;
   logic       pll_locked;
   logic       button_rst;
   logic       periph_rst;
   logic       cpu_rst;
   logic       seq_done;
   logic [7:0] relock_count;

   int checks;
   int errors;
   int exp_relock;

   reset_sequencer #(
      .LOCK_STABLE_CYCLES (16),
      .CPU_DELAY_CYCLES   (8),
      .DEBOUNCE_CYCLES    (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pll_locked   (pll_locked),
      .button_rst   (button_rst),
      .periph_rst   (periph_rst),
      .cpu_rst      (cpu_rst),
      .seq_done     (seq_done),
      .relock_count (relock_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion before it");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      pll_locked = 1'b0;
      button_rst = 1'b0;
      exp_relock = 0;
      tick(3);
      checks++;
      if ({periph_rst, cpu_rst, seq_done} !== 3'b110 || relock_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_values: got p=%b c=%b d=%b r=%0d, expected p=1 c=1 d=0 r=0",
                  periph_rst, cpu_rst, seq_done, relock_count);
      end
      rst_n = 1'b1;   // just after edge 0
   endtask

   task automatic test_power_up();
      tick(9);
      pll_locked = 1'b1;   // first sampled at edge 10
      tick(18);            // edge 27
      checks++;
      if (periph_rst !== 1'b1) begin
         errors++;
         $display("FAIL pwr_periph_e27: got %b expected 1", periph_rst);
      end
      tick(1);             // edge 28
      checks++;
      if (periph_rst !== 1'b0 || cpu_rst !== 1'b1) begin
         errors++;
         $display("FAIL pwr_periph_e28: got p=%b c=%b expected p=0 c=1", periph_rst, cpu_rst);
      end
      tick(7);             // edge 35
      checks++;
      if (cpu_rst !== 1'b1 || seq_done !== 1'b0) begin
         errors++;
         $display("FAIL pwr_cpu_e35: got c=%b d=%b expected c=1 d=0", cpu_rst, seq_done);
      end
      tick(1);             // edge 36
      checks++;
      if (cpu_rst !== 1'b0 || seq_done !== 1'b1 || relock_count !== 8'd0) begin
         errors++;
         $display("FAIL pwr_cpu_e36: got c=%b d=%b r=%0d expected c=0 d=1 r=0",
                  cpu_rst, seq_done, relock_count);
      end
   endtask

   task automatic test_lock_loss();
      pll_locked = 1'b0;   // first sampled at edge m
      tick(2);             // m+1
      checks++;
      if (cpu_rst !== 1'b0 || periph_rst !== 1'b0) begin
         errors++;
         $display("FAIL loss_m1: got p=%b c=%b expected p=0 c=0", periph_rst, cpu_rst);
      end
      tick(1);             // m+2
      exp_relock = 1;
      checks++;
      if ({periph_rst, cpu_rst, seq_done} !== 3'b110 || relock_count !== 8'(exp_relock)) begin
         errors++;
         $display("FAIL loss_m2: got p=%b c=%b d=%b r=%0d expected p=1 c=1 d=0 r=%0d",
                  periph_rst, cpu_rst, seq_done, relock_count, exp_relock);
      end
      tick(2);
      pll_locked = 1'b1;   // first sampled at edge k
      tick(18);            // k+17
      checks++;
      if (periph_rst !== 1'b1) begin
         errors++;
         $display("FAIL relock_periph_k17: got %b expected 1", periph_rst);
      end
      tick(1);             // k+18
      checks++;
      if (periph_rst !== 1'b0) begin
         errors++;
         $display("FAIL relock_periph_k18: got %b expected 0", periph_rst);
      end
      tick(7);
      checks++;
      if (cpu_rst !== 1'b1) begin
         errors++;
         $display("FAIL relock_cpu_k25: got %b expected 1", cpu_rst);
      end
      tick(1);
      checks++;
      if (cpu_rst !== 1'b0 || seq_done !== 1'b1 || relock_count !== 8'(exp_relock)) begin
         errors++;
         $display("FAIL relock_cpu_k26: got c=%b d=%b r=%0d expected c=0 d=1 r=%0d",
                  cpu_rst, seq_done, relock_count, exp_relock);
      end
   endtask

   task automatic test_glitch();
      pll_locked = 1'b0;
      tick(4);
      exp_relock = exp_relock + 1;
      pll_locked = 1'b1;   // first sampled at edge k, LOCK_WAIT entered at k+2
      tick(13);            // k+12: ten counts done
      pll_locked = 1'b0;   // low at edge k+13 only
      tick(1);
      pll_locked = 1'b1;   // re-lock first sampled at k' = k+14
      tick(18);            // k'+17
      checks++;
      if (periph_rst !== 1'b1) begin
         errors++;
         $display("FAIL glitch_periph_k17: got %b expected 1", periph_rst);
      end
      tick(1);             // k'+18
      checks++;
      if (periph_rst !== 1'b0 || relock_count !== 8'(exp_relock)) begin
         errors++;
         $display("FAIL glitch_periph_k18: got p=%b r=%0d expected p=0 r=%0d",
                  periph_rst, relock_count, exp_relock);
      end
      tick(8);
      checks++;
      if (seq_done !== 1'b1) begin
         errors++;
         $display("FAIL glitch_run: got seq_done=%b expected 1", seq_done);
      end
   endtask

   task automatic test_button();
      button_rst = 1'b1;
      tick(3);
      button_rst = 1'b0;
      tick(8);
      checks++;
      if (seq_done !== 1'b1 || cpu_rst !== 1'b0) begin
         errors++;
         $display("FAIL btn_short: got d=%b c=%b expected d=1 c=0", seq_done, cpu_rst);
      end
      button_rst = 1'b1;   // first sampled at edge b
      tick(4);             // b+3
      button_rst = 1'b0;
      tick(2);             // b+5
      checks++;
      if (cpu_rst !== 1'b0) begin
         errors++;
         $display("FAIL btn_b5: got cpu_rst=%b expected 0", cpu_rst);
      end
      tick(1);             // b+6
      checks++;
      if ({periph_rst, cpu_rst, seq_done} !== 3'b110 || relock_count !== 8'(exp_relock)) begin
         errors++;
         $display("FAIL btn_b6: got p=%b c=%b d=%b r=%0d expected p=1 c=1 d=0 r=%0d",
                  periph_rst, cpu_rst, seq_done, relock_count, exp_relock);
      end
      tick(16);            // b+22
      checks++;
      if (periph_rst !== 1'b1) begin
         errors++;
         $display("FAIL btn_restart_b22: got %b expected 1", periph_rst);
      end
      tick(1);             // b+23
      checks++;
      if (periph_rst !== 1'b0) begin
         errors++;
         $display("FAIL btn_restart_b23: got %b expected 0", periph_rst);
      end
      tick(8);             // b+31
      checks++;
      if (cpu_rst !== 1'b0 || seq_done !== 1'b1) begin
         errors++;
         $display("FAIL btn_restart_run: got c=%b d=%b expected c=0 d=1", cpu_rst, seq_done);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 300; i++) begin
         pll_locked = 1'b0;
         tick(3);
         pll_locked = 1'b1;
         tick(27);
         if (exp_relock < 255) exp_relock = exp_relock + 1;
      end
      checks++;
      if (relock_count !== 8'(exp_relock) || relock_count !== 8'd255) begin
         errors++;
         $display("FAIL sat_count: got %0d expected %0d", relock_count, exp_relock);
      end
      checks++;
      if (seq_done !== 1'b1) begin
         errors++;
         $display("FAIL sat_run: got seq_done=%b expected 1", seq_done);
      end
   endtask

   task automatic test_async_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({periph_rst, cpu_rst, seq_done} !== 3'b110 || relock_count !== 8'd0) begin
         errors++;
         $display("FAIL async_reset: got p=%b c=%b d=%b r=%0d expected p=1 c=1 d=0 r=0",
                  periph_rst, cpu_rst, seq_done, relock_count);
      end
      tick(2);
      rst_n = 1'b1;
      tick(5);
      checks++;
      if (periph_rst !== 1'b1 || relock_count !== 8'd0) begin
         errors++;
         $display("FAIL post_reset: got p=%b r=%0d expected p=1 r=0", periph_rst, relock_count);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_power_up();
      test_lock_loss();
      test_glitch();
      test_button();
      test_saturation();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-locked cycles required before peripheral reset release (min 1).
REQ-002 Parameter CPU_DELAY_CYCLES, default 64: cycles between peripheral reset release and CPU reset release (min 1).
REQ-003 Parameter DEBOUNCE_CYCLES, default 65536: consecutive synchronized-high button samples that count as a press (min 1).
REQ-004 Port clk  input  1  single clock for the block; cpu_clk from the clock-generation stage; all flops on its rising edge.
REQ-005 Port rst_n  input  1  reset is asynchronous and active-low; assertion is immediate; deassertion is synchronous to clk, provided by the integrator.
REQ-006 Port pll_locked  input  1  PLL lock status; asynchronous to clk.
REQ-007 Port button_rst  input  1  user reset button, active-high; asynchronous and bouncy.
REQ-008 Port periph_rst  output  1  active-high reset for peripherals (UART, PWM glue, memories).
REQ-009 Port cpu_rst  output  1  active-high reset for the CPU core.
REQ-010 Port seq_done  output  1  high only while state = RUN.
REQ-011 Port relock_count  output  8  count of lock-loss events that occurred in RUN.

Function
REQ-012 pll_locked and button_rst SHALL each pass through a 2-flop synchronizer (locked_s, button_s) before any use.
REQ-013 btn_deb SHALL become 1 after DEBOUNCE_CYCLES consecutive button_s=1 samples and return to 0 on the first button_s=0 sample, which also clears the debounce counter.
REQ-014 The FSM SHALL have exactly four states: WAIT_LOCK, LOCK_WAIT, PERIPH_RUN, RUN; one shared down-counter or up-counter sized for max(LOCK_STABLE_CYCLES, CPU_DELAY_CYCLES).
REQ-015 WAIT_LOCK -> LOCK_WAIT on the first edge with locked_s=1 and btn_deb=0; counter cleared to 0.
REQ-016 LOCK_WAIT: each edge with locked_s=1 increments counter; edge with counter = LOCK_STABLE_CYCLES-1 -> PERIPH_RUN, counter cleared.
REQ-017 PERIPH_RUN: counter increments each edge; edge with counter = CPU_DELAY_CYCLES-1 -> RUN.
REQ-018 In LOCK_WAIT, PERIPH_RUN or RUN, locked_s=0 or btn_deb=1 SHALL force the next state to WAIT_LOCK, overriding every other transition.
REQ-019 periph_rst SHALL be 0 exactly in PERIPH_RUN and RUN; cpu_rst and seq_done SHALL be 0 and 1 respectively exactly in RUN; all are registered and change on the same edge as the state register.
REQ-020 relock_count SHALL increment by 1 on each RUN -> WAIT_LOCK transition with locked_s=0, including the case of a simultaneous button press; it saturates at 255 and never wraps.
REQ-021 A button-only exit from RUN SHALL NOT change relock_count.
REQ-022 Latency: pll_locked high first sampled at edge k -> periph_rst falls at edge k+2+LOCK_STABLE_CYCLES -> cpu_rst falls CPU_DELAY_CYCLES edges later.
REQ-023 Latency: pll_locked low first sampled at edge m -> cpu_rst=1 and periph_rst=1 at edge m+2.
REQ-024 A glitch of locked_s low for 1 cycle during LOCK_WAIT SHALL restart the full LOCK_STABLE_CYCLES count.

Reset
REQ-025 rst_n=0 SHALL asynchronously set state=WAIT_LOCK, periph_rst=1, cpu_rst=1, seq_done=0, relock_count=0, and all counters, synchronizer flops and btn_deb to 0.
REQ-026 rst_n asserted mid-sequence (any state) SHALL yield the REQ-025 values immediately, without waiting for a clk edge.
REQ-027 relock_count SHALL be cleared only by rst_n.

Verification (bench parameters LOCK_STABLE_CYCLES=16, CPU_DELAY_CYCLES=8, DEBOUNCE_CYCLES=4)
REQ-028 Power-up: rst_n released, pll_locked rises and is first sampled at edge 10 -> periph_rst falls at edge 28, cpu_rst and seq_done change at edge 36, relock_count=0.
REQ-029 Lock loss in RUN: pll_locked falls and is first sampled at edge m -> both resets =1 at m+2, relock_count=1; relock -> the full 16+8 sequence repeats.
REQ-030 Glitch: pll_locked low for 1 cycle during LOCK_WAIT after 10 counts -> periph_rst release delayed by a full 16 counts from re-lock; relock_count unchanged.
REQ-031 Button: 3-cycle high pulse -> no effect; 4-cycle high pulse in RUN -> both resets assert 2+4 edges after the first high sample, relock_count unchanged, sequence restarts after release.
REQ-032 Saturation and async reset: 300 lock-loss events -> relock_count=255; rst_n pulsed low between clock edges -> all outputs at reset values before the next edge.
